// File: rtl/memory_control.sv
// memory_control: single-port RAM arbiter for instruction fetch and data access.
// Data requests take priority over instruction fetches. Returned RAM data is captured
// into per-requester load registers. Completion is signalled by one-cycle ready pulses,
// and combinational wait signals stall the core until then.
// Ports:
//   CLK, nRST            clock; asynchronous active-high reset
//   imemRen, imemaddr    instruction fetch request and address
//   dmmRen, dmmWen       data read/write request
//   dmmaddr, dmmstore    data address and data to write
//   ramload, busy_o      RAM read data; RAM busy (1 = access not finished)
//   Ren, Wen             RAM read/write strobes
//   ramaddr, ramstore    RAM address and write data
//   imemload, dmmload    registered instruction/data read data
//   i_ready, d_ready     one-cycle completion pulses
//   i_wait, d_wait       stall signals back to the core
module memory_control (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemRen,
    input  logic [31:0] imemaddr,
    input  logic        dmmRen,
    input  logic        dmmWen,
    input  logic [31:0] dmmaddr,
    input  logic [31:0] dmmstore,
    input  logic [31:0] ramload,
    input  logic        busy_o,
    output logic        Ren,
    output logic        Wen,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic [31:0] imemload,
    output logic [31:0] dmmload,
    output logic        i_ready,
    output logic        d_ready,
    output logic        i_wait,
    output logic        d_wait
);
    typedef enum logic [1:0] {IDLE, IREQ, DREQ} state_t;

    state_t      r_state;
    logic [31:0] r_imemload;
    logic [31:0] r_dmmload;
    logic        r_i_ready;
    logic        r_d_ready;
    logic        w_dreq;
    logic        w_in_i;
    logic        w_in_d;

    assign w_dreq = dmmRen | dmmWen;
    assign w_in_i = r_state == IREQ;
    assign w_in_d = r_state == DREQ;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_state    <= IDLE;
            r_imemload <= '0;
            r_dmmload  <= '0;
            r_i_ready  <= 1'b0;
            r_d_ready  <= 1'b0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            case (r_state)
                IDLE: r_state <= w_dreq ? DREQ : (imemRen ? IREQ : IDLE);
                IREQ: begin
                    if (!imemRen) begin
                        r_state <= IDLE;
                    end else if (!busy_o) begin
                        r_imemload <= ramload;
                        r_i_ready  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                DREQ: begin
                    if (!w_dreq) begin
                        r_state <= IDLE;
                    end else if (!busy_o) begin
                        // writes complete without touching the data load register
                        if (!dmmWen) r_dmmload <= ramload;
                        r_d_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // strobes derive from the state register, so an async reset drops them at once
    assign Ren      = w_in_i | (w_in_d & ~dmmWen);
    assign Wen      = w_in_d & dmmWen;
    assign ramaddr  = w_in_i ? imemaddr : (w_in_d ? dmmaddr : '0);
    assign ramstore = Wen ? dmmstore : '0;
    assign imemload = r_imemload;
    assign dmmload  = r_dmmload;
    assign i_ready  = r_i_ready;
    assign d_ready  = r_d_ready;
    assign i_wait   = imemRen & ~r_i_ready;
    assign d_wait   = w_dreq & ~r_d_ready;
endmodule

// File: tb/tb_memory_control.sv
// tb_memory_control: scoreboard bench for the instruction/data RAM arbiter.
module tb_memory_control;
    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        imemRen = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        dmmRen = 1'b0;
    logic        dmmWen = 1'b0;
    logic [31:0] dmmaddr = '0;
    logic [31:0] dmmstore = '0;
    logic [31:0] ramload = '0;
    logic        busy_o = 1'b0;
    logic        Ren;
    logic        Wen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] imemload;
    logic [31:0] dmmload;
    logic        i_ready;
    logic        d_ready;
    logic        i_wait;
    logic        d_wait;

    int checks = 0;
    int errors = 0;
    logic [31:0] iq[$];
    logic [31:0] dq[$];

    memory_control dut (
        .CLK(CLK), .nRST(nRST), .imemRen(imemRen), .imemaddr(imemaddr),
        .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
        .ramload(ramload), .busy_o(busy_o), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr),
        .ramstore(ramstore), .imemload(imemload), .dmmload(dmmload),
        .i_ready(i_ready), .d_ready(d_ready), .i_wait(i_wait), .d_wait(d_wait)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // completions pop the scoreboard; a pulse with nothing outstanding is an error
    always @(negedge CLK) begin
        if (i_ready) begin
            if (iq.size() == 0) chk("i_unexpected", 32'(i_ready), 32'd0);
            else chk("sb_imemload", imemload, iq.pop_front());
        end
        if (d_ready) begin
            if (dq.size() == 0) chk("d_unexpected", 32'(d_ready), 32'd0);
            else chk("sb_dmmload", dmmload, dq.pop_front());
        end
    end

    task automatic step;
        @(negedge CLK);
    endtask

    initial begin
        // reset with a pending fetch
        imemRen = 1'b1;
        step;
        #1;
        chk("rst_Ren", 32'(Ren), 32'd0);
        chk("rst_Wen", 32'(Wen), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_dmmload", dmmload, 32'd0);
        chk("rst_i_ready", 32'(i_ready), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        chk("rst_i_wait", 32'(i_wait), 32'd1);
        // fetch under busy
        nRST = 1'b0;
        imemaddr = 32'h11119999;
        ramload = 32'h99991111;
        busy_o = 1'b1;
        iq.push_back(32'h99991111);
        for (int k = 0; k < 3; k++) begin
            step;
            #1;
            chk("busy_Ren", 32'(Ren), 32'd1);
            chk("busy_ramaddr", ramaddr, 32'h11119999);
            chk("busy_i_wait", 32'(i_wait), 32'd1);
            chk("busy_i_ready", 32'(i_ready), 32'd0);
        end
        busy_o = 1'b0;
        step;
        #1;
        chk("fetch_i_ready", 32'(i_ready), 32'd1);
        chk("fetch_i_wait", 32'(i_wait), 32'd0);
        chk("fetch_imemload", imemload, 32'h99991111);
        imemRen = 1'b0;
        step;
        #1;
        chk("fetch_pulse_end", 32'(i_ready), 32'd0);
        chk("idle_Ren", 32'(Ren), 32'd0);
        // data read wins over a simultaneous fetch
        dmmRen = 1'b1;
        imemRen = 1'b1;
        dmmaddr = 32'hABCD1234;
        dq.push_back(32'h99991111);
        step;
        #1;
        chk("dr_Ren", 32'(Ren), 32'd1);
        chk("dr_Wen", 32'(Wen), 32'd0);
        chk("dr_ramaddr", ramaddr, 32'hABCD1234);
        chk("dr_d_wait", 32'(d_wait), 32'd1);
        chk("dr_i_wait", 32'(i_wait), 32'd1);
        step;
        #1;
        chk("dr_d_ready", 32'(d_ready), 32'd1);
        chk("dr_d_wait_done", 32'(d_wait), 32'd0);
        chk("dr_dmmload", dmmload, 32'h99991111);
        chk("dr_no_i_ready", 32'(i_ready), 32'd0);
        dmmRen = 1'b0;
        step;
        #1;
        chk("fol_ramaddr", ramaddr, 32'h11119999);
        chk("fol_Ren", 32'(Ren), 32'd1);
        ramload = 32'h5A5A0F0F;
        iq.push_back(32'h5A5A0F0F);
        step;
        #1;
        chk("fol_i_ready", 32'(i_ready), 32'd1);
        chk("fol_dmmload_kept", dmmload, 32'h99991111);
        imemRen = 1'b0;
        // data write, then read also raised: write still wins
        dmmWen = 1'b1;
        dmmstore = 32'h9876DCBA;
        busy_o = 1'b1;
        ramload = 32'hDEADBEEF;
        dq.push_back(32'h99991111);
        step;
        #1;
        chk("wr_Wen", 32'(Wen), 32'd1);
        chk("wr_Ren", 32'(Ren), 32'd0);
        chk("wr_ramstore", ramstore, 32'h9876DCBA);
        chk("wr_ramaddr", ramaddr, 32'hABCD1234);
        dmmRen = 1'b1;
        #1;
        chk("wr_both_Wen", 32'(Wen), 32'd1);
        chk("wr_both_Ren", 32'(Ren), 32'd0);
        busy_o = 1'b0;
        step;
        #1;
        chk("wr_d_ready", 32'(d_ready), 32'd1);
        chk("wr_dmmload_kept", dmmload, 32'h99991111);
        dmmWen = 1'b0;
        dmmRen = 1'b0;
        // abort a busy data read
        step;
        dmmRen = 1'b1;
        busy_o = 1'b1;
        ramload = 32'h12345678;
        step;
        #1;
        chk("ab_Ren", 32'(Ren), 32'd1);
        chk("ab_ramstore", ramstore, 32'd0);
        dmmRen = 1'b0;
        step;
        #1;
        chk("ab_d_ready", 32'(d_ready), 32'd0);
        chk("ab_Ren_idle", 32'(Ren), 32'd0);
        chk("ab_dmmload", dmmload, 32'h99991111);
        step;
        #1;
        chk("ab_d_ready2", 32'(d_ready), 32'd0);
        // async reset in the middle of a fetch
        imemRen = 1'b1;
        step;
        #1;
        chk("ar_Ren_before", 32'(Ren), 32'd1);
        chk("ar_imemload_before", imemload, 32'h5A5A0F0F);
        #1;
        nRST = 1'b1;
        #1;
        chk("ar_Ren", 32'(Ren), 32'd0);
        chk("ar_ramaddr", ramaddr, 32'd0);
        chk("ar_imemload", imemload, 32'd0);
        chk("ar_i_ready", 32'(i_ready), 32'd0);
        step;
        chk("sb_iq_drained", 32'(iq.size()), 32'd0);
        chk("sb_dq_drained", 32'(dq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
